// File: rtl/sort_sched_pkg.sv
// Shared types for the two-client sort scheduler: FSM states, client id and
// small helpers for mapping between client ids and one-hot grants.
package sort_sched_pkg;

  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [$clog2(NUM_CLIENTS)-1:0] client_id_t;

  function automatic client_id_t other_client(input client_id_t id);
    return ~id;
  endfunction

  function automatic logic [NUM_CLIENTS-1:0] id_to_onehot(input client_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the favoured client and
// moves to the client that was not served whenever advance_i is pulsed.
module rr_arb2
  import sort_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic                   advance_i,
  input  client_id_t             served_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output client_id_t             gnt_id_o
);

  client_id_t ptr_q, ptr_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = other_client(served_i);
    end
  end

  always_comb begin
    gnt_id_o = ptr_q;
    if (!req_i[ptr_q] && req_i[other_client(ptr_q)]) begin
      gnt_id_o = other_client(ptr_q);
    end
    gnt_o = req_i[gnt_id_o] ? id_to_onehot(gnt_id_o) : '0;
  end

endmodule

// File: rtl/sort_sched.sv
// Round-robin scheduler sharing one streaming sorter between two clients.
// Define SORT_SCHED_WATCHDOG_EN to abort a stalled DRAIN after TIMEOUT cycles.
module sort_sched
  import sort_sched_pkg::*;
#(
  parameter int N       = 128,
  parameter int W       = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic [W-1:0] c0_data,
  input  logic         c0_valid,
  output logic         c0_ready,
  input  logic [W-1:0] c1_data,
  input  logic         c1_valid,
  output logic         c1_ready,
  output logic [W-1:0] srt_in,
  output logic         srt_en_in,
  input  logic [W-1:0] srt_out,
  input  logic         srt_en_out,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_id,
  output logic         busy,
  output logic         err_timeout
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  client_id_t    owner_q, owner_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [W-1:0]  srt_in_q, srt_in_d;
  logic          srt_en_in_q, srt_en_in_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  client_id_t    out_id_q, out_id_d;
  logic          err_q, err_d;

  logic          advance;
  logic [1:0]    arb_gnt;
  client_id_t    arb_id;
  logic          accept;
  logic [W-1:0]  key_sel;
  logic          wd_expire;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .advance_i (advance),
    .served_i  (owner_q),
    .gnt_o     (arb_gnt),
    .gnt_id_o  (arb_id)
  );

  assign c0_ready = (state_q == LOAD) && gnt_q[0];
  assign c1_ready = (state_q == LOAD) && gnt_q[1];
  assign accept   = (c0_valid && c0_ready) || (c1_valid && c1_ready);
  assign key_sel  = owner_q ? c1_data : c0_data;

`ifdef SORT_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;

  // Counts consecutive DRAIN cycles without a sorter beat.
  always_comb begin
    wd_cnt_d  = '0;
    wd_expire = 1'b0;
    if (state_q == DRAIN && !srt_en_out) begin
      wd_cnt_d  = wd_cnt_q + TW'(1);
      wd_expire = (wd_cnt_d == TW'(TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    srt_in_d    = srt_in_q;
    srt_en_in_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    err_d       = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = LOAD;
          gnt_d     = arb_gnt;
          owner_d   = arb_id;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end

      LOAD: begin
        if (accept) begin
          srt_in_d    = key_sel;
          srt_en_in_d = 1'b1;
          in_cnt_d    = in_cnt_q + CW'(1);
          if (in_cnt_q == LAST) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (srt_en_out) begin
          out_data_d  = srt_out;
          out_valid_d = 1'b1;
          out_id_d    = owner_q;
          out_cnt_d   = out_cnt_q + CW'(1);
          if (out_cnt_q == LAST) begin
            state_d = IDLE;
            gnt_d   = '0;
            advance = 1'b1;
          end
        end else if (wd_expire) begin
          // Abandon the stalled frame; the other client is favoured next.
          err_d   = 1'b1;
          state_d = IDLE;
          gnt_d   = '0;
          advance = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      srt_in_q    <= '0;
      srt_en_in_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      srt_in_q    <= srt_in_d;
      srt_en_in_q <= srt_en_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign srt_in      = srt_in_q;
  assign srt_en_in   = srt_en_in_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule
